// File: rtl/lcd_pkg.sv
// Shared state encoding, init ROM and command helpers for the HD44780-style
// LCD write controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } lcd_state_t;

   localparam int INIT_LEN = 6;

   // 8-bit/2-line function set three times, display on, clear, entry mode.
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
      8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
   };

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   // Return-home ignores bit 0 of the opcode, so 0x03 is also a long command.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Shared down-counter for every timed phase of the LCD controller; o_done is
// high while the count sits at zero.
module lcd_timer #(
   parameter int WIDTH = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count <= '0;
      end else if (i_load) begin
         count <= i_load_val;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign o_done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: powers the panel, replays the HD44780 init sequence,
// then turns each accepted command/data byte into a timed 8-bit write cycle.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP_CYC = 750000,
   parameter int T_SETUP_CYC = 4,
   parameter int T_EN_CYC    = 12,
   parameter int T_HOLD_CYC  = 4,
   parameter int T_CMD_CYC   = 2000,
   parameter int T_CLR_CYC   = 82000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_lcd_on,
   input  logic       i_cmd_vld,
   input  logic       i_cmd_rs,
   input  logic [7:0] i_cmd_data,
   output logic       o_cmd_rdy,
   output logic       o_init_done,
   output logic       o_lcd_on,
   output logic       o_lcd_en,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic [7:0] o_lcd_data
);

   localparam int T_MAX = max_int(max_int(max_int(T_PWRUP_CYC, T_SETUP_CYC),
                                          max_int(T_EN_CYC, T_HOLD_CYC)),
                                  max_int(T_CMD_CYC, T_CLR_CYC));
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   lcd_state_t    state;
   logic [2:0]    init_idx;
   logic          tmr_load;
   logic          tmr_done;
   logic [TW-1:0] tmr_val;

   lcd_timer #(
      .WIDTH(TW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .o_done     (tmr_done)
   );

   // The timer is primed with the duration of whichever state comes next, on
   // the same edge the FSM moves; idle-like states keep it primed every cycle.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_OFF: begin
            tmr_load = 1'b1;
            tmr_val  = TW'(T_PWRUP_CYC - 1);
         end
         ST_INIT, ST_IDLE: begin
            tmr_load = 1'b1;
            tmr_val  = TW'(T_SETUP_CYC - 1);
         end
         ST_SETUP: begin
            tmr_load = tmr_done;
            tmr_val  = TW'(T_EN_CYC - 1);
         end
         ST_PULSE: begin
            tmr_load = tmr_done;
            tmr_val  = TW'(T_HOLD_CYC - 1);
         end
         ST_HOLD: begin
            tmr_load = tmr_done;
            tmr_val  = is_long_cmd(o_lcd_rs, o_lcd_data) ? TW'(T_CLR_CYC - 1)
                                                         : TW'(T_CMD_CYC - 1);
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ST_OFF;
         init_idx    <= '0;
         o_cmd_rdy   <= 1'b0;
         o_init_done <= 1'b0;
         o_lcd_on    <= 1'b0;
         o_lcd_en    <= 1'b0;
         o_lcd_rs    <= 1'b0;
         o_lcd_data  <= '0;
      end else if (!i_lcd_on) begin
         state       <= ST_OFF;
         init_idx    <= '0;
         o_cmd_rdy   <= 1'b0;
         o_init_done <= 1'b0;
         o_lcd_on    <= 1'b0;
         o_lcd_en    <= 1'b0;
         o_lcd_rs    <= 1'b0;
         o_lcd_data  <= '0;
      end else begin
         case (state)
            ST_OFF: begin
               o_lcd_on <= 1'b1;
               state    <= ST_PWRUP;
            end
            ST_PWRUP: begin
               if (tmr_done) begin
                  init_idx <= '0;
                  state    <= ST_INIT;
               end
            end
            ST_INIT: begin
               o_lcd_rs   <= 1'b0;
               o_lcd_data <= INIT_ROM[init_idx];
               state      <= ST_SETUP;
            end
            ST_IDLE: begin
               if (i_cmd_vld && o_cmd_rdy) begin
                  o_lcd_rs   <= i_cmd_rs;
                  o_lcd_data <= i_cmd_data;
                  o_cmd_rdy  <= 1'b0;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_done) begin
                  o_lcd_en <= 1'b1;
                  state    <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (tmr_done) begin
                  o_lcd_en <= 1'b0;
                  state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (tmr_done) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // The last ROM byte finishing is what completes initialisation.
               if (tmr_done) begin
                  if (o_init_done || (init_idx == 3'(INIT_LEN - 1))) begin
                     o_init_done <= 1'b1;
                     o_cmd_rdy   <= 1'b1;
                     state       <= ST_IDLE;
                  end else begin
                     init_idx <= init_idx + 3'd1;
                     state    <= ST_INIT;
                  end
               end
            end
            default: begin
               state <= ST_OFF;
            end
         endcase
      end
   end

   assign o_lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: a timeline model of the LCD write protocol
// is compared against the pins every cycle, with literal timing anchors.
module tb_lcd_ctrl;

   localparam int P_PWRUP = 20;
   localparam int P_SETUP = 2;
   localparam int P_EN    = 3;
   localparam int P_HOLD  = 2;
   localparam int P_CMD   = 5;
   localparam int P_CLR   = 10;
   localparam int INIT_CYCLES = 104;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcd_on = 1'b0;
   logic       vld = 1'b0;
   logic       rs = 1'b0;
   logic [7:0] data = 8'h00;

   logic       cmd_rdy;
   logic       init_done;
   logic       lcd_on_pin;
   logic       lcd_en;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] rom_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   always #5 clk = ~clk;

   lcd_ctrl #(
      .T_PWRUP_CYC (P_PWRUP),
      .T_SETUP_CYC (P_SETUP),
      .T_EN_CYC    (P_EN),
      .T_HOLD_CYC  (P_HOLD),
      .T_CMD_CYC   (P_CMD),
      .T_CLR_CYC   (P_CLR)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_lcd_on    (lcd_on),
      .i_cmd_vld   (vld),
      .i_cmd_rs    (rs),
      .i_cmd_data  (data),
      .o_cmd_rdy   (cmd_rdy),
      .o_init_done (init_done),
      .o_lcd_on    (lcd_on_pin),
      .o_lcd_en    (lcd_en),
      .o_lcd_rs    (lcd_rs),
      .o_lcd_rw    (lcd_rw),
      .o_lcd_data  (lcd_data)
   );

   function automatic void check_val(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
      end
   endfunction

   function automatic int exec_cycles(input logic r, input logic [7:0] d);
      return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_CLR : P_CMD;
   endfunction

   // Reference model: expected pin values after each edge.
   bit         m_pwr = 0, m_done = 0, m_busy = 0, m_rs_known = 1;
   int         m_t = 0, m_k = 0, m_len = 0;
   logic       e_on = 0, e_en = 0, e_rs = 0, e_rdy = 0, e_done = 0;
   logic [7:0] e_data = 0;

   // Init is a fixed timeline: byte i starts one cycle after byte i-1's wait ends.
   task automatic model_init_step(input int t);
      int s;
      int d;
      s = P_PWRUP + 1;
      e_en = 0; e_rdy = 0; e_done = 0; e_data = 8'h00;
      for (int i = 0; i < 6; i++) begin
         d = P_SETUP + P_EN + P_HOLD + exec_cycles(1'b0, rom_bytes[i]);
         if (t >= s) begin
            e_data = rom_bytes[i];
            e_rs = 1'b0;
            m_rs_known = 1;
            e_en = (t - s >= P_SETUP) && (t - s < P_SETUP + P_EN);
         end
         if (i == 5 && t == s + d) begin
            e_done = 1; e_rdy = 1; m_done = 1;
         end
         s = s + d + 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pwr = 0; m_done = 0; m_busy = 0; m_rs_known = 1;
         e_on = 0; e_en = 0; e_rs = 0; e_rdy = 0; e_done = 0; e_data = 0;
      end else if (!lcd_on) begin
         m_pwr = 0; m_done = 0; m_busy = 0; m_rs_known = 0;
         e_on = 0; e_en = 0; e_rdy = 0; e_done = 0; e_data = 0;
      end else if (!m_pwr) begin
         m_pwr = 1; m_t = 0; e_on = 1;
      end else if (!m_done) begin
         m_t++;
         model_init_step(m_t);
      end else if (!m_busy) begin
         if (vld) begin
            m_busy = 1; m_k = 0;
            m_len = P_SETUP + P_EN + P_HOLD + exec_cycles(rs, data);
            e_rs = rs; e_data = data; e_rdy = 0; e_en = 0;
         end
      end else begin
         m_k++;
         e_en = (m_k >= P_SETUP) && (m_k < P_SETUP + P_EN);
         if (m_k == m_len) begin
            m_busy = 0; e_rdy = 1;
         end
      end
   end

   task automatic check_output();
      check_val("lcd_on", lcd_on_pin, e_on);
      check_val("lcd_en", lcd_en, e_en);
      check_val("cmd_rdy", cmd_rdy, e_rdy);
      check_val("init_done", init_done, e_done);
      check_val("lcd_data", lcd_data, e_data);
      check_val("lcd_rw", lcd_rw, 0);
      if (m_rs_known) check_val("lcd_rs", lcd_rs, e_rs);
   endtask

   always @(negedge clk) begin
      cyc++;
      check_output();
   end

   // EN pulse recorder: byte, RS and width of every strobe.
   logic [7:0] pq_data [$];
   logic       pq_rs [$];
   int         pq_w [$];
   logic       prev_en = 0;
   int         pw = 0;

   always @(negedge clk) begin
      if (lcd_en && !prev_en) begin
         pq_data.push_back(lcd_data);
         pq_rs.push_back(lcd_rs);
         pw = 1;
      end else if (lcd_en) begin
         pw++;
      end else if (prev_en) begin
         pq_w.push_back(pw);
      end
      prev_en = lcd_en;
   end

   task automatic clear_pulses();
      pq_data.delete();
      pq_rs.delete();
      pq_w.delete();
   endtask

   task automatic wait_init(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!init_done && n < 2000);
   endtask

   task automatic check_init_pulses(input string tag);
      check_val({tag, "_pulse_count"}, pq_data.size(), 6);
      for (int i = 0; i < 6 && i < pq_data.size(); i++) begin
         check_val($sformatf("%s_byte%0d", tag, i), pq_data[i], rom_bytes[i]);
         check_val($sformatf("%s_rs%0d", tag, i), pq_rs[i], 0);
         if (i < pq_w.size()) check_val($sformatf("%s_width%0d", tag, i), pq_w[i], P_EN);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic apply_stimulus(input logic r, input logic [7:0] d, input bit hold,
                                 output int n);
      bit took;
      rs = r; data = d; vld = 1'b1;
      took = 0; n = 0;
      while (!took && n < 5000) begin
         took = cmd_rdy;
         @(negedge clk);
         n++;
      end
      check_val("accept_seen", took, 1);
      if (!hold) vld = 1'b0;
   endtask

   task automatic measure_latency(output int lat, output int rise);
      lat = 0; rise = -1;
      while (!cmd_rdy && lat < 5000) begin
         if (lcd_en && rise < 0) rise = lat;
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int n, lat, rise, base;
      logic       rr;
      logic [7:0] dd;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_val("off_lcd_on", lcd_on_pin, 0);

      // Power up with a byte already waiting; it must not be taken during init.
      clear_pulses();
      lcd_on = 1'b1;
      rs = 1'b1; data = 8'h41; vld = 1'b1;
      wait_init(n);
      check_val("init_cycles", n, INIT_CYCLES);
      check_init_pulses("init");
      check_val("rdy_after_init", cmd_rdy, 1);

      apply_stimulus(1'b1, 8'h41, 1'b0, n);
      check_val("first_accept_wait", n, 1);
      check_val("data_byte_rs", lcd_rs, 1);
      check_val("data_byte_data", lcd_data, 8'h41);
      measure_latency(lat, rise);
      check_val("lat_0x41", lat, 12);
      check_val("en_rise_0x41", rise, 2);

      apply_stimulus(1'b0, 8'h01, 1'b0, n);
      measure_latency(lat, rise);
      check_val("lat_clear", lat, 17);
      apply_stimulus(1'b1, 8'h01, 1'b0, n);
      measure_latency(lat, rise);
      check_val("lat_data_01", lat, 12);

      // Back-to-back bytes with vld held throughout.
      clear_pulses();
      apply_stimulus(1'b1, 8'h48, 1'b1, n);
      apply_stimulus(1'b1, 8'h49, 1'b0, n);
      check_val("b2b_accept_gap", n, 13);
      measure_latency(lat, rise);
      repeat (2) @(negedge clk);
      check_val("b2b_pulse_count", pq_data.size(), 2);
      if (pq_data.size() == 2) begin
         check_val("b2b_first", pq_data[0], 8'h48);
         check_val("b2b_second", pq_data[1], 8'h49);
      end

      // Random traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         rr = 1'($urandom_range(0, 1));
         dd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
         apply_stimulus(rr, dd, 1'($urandom_range(0, 1)), n);
      end
      vld = 1'b0;
      measure_latency(lat, rise);

      // Drop power mid-pulse, then re-enable.
      apply_stimulus(1'b1, 8'h5A, 1'b0, n);
      n = 0;
      while (!lcd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("drop_en_seen", lcd_en, 1);
      lcd_on = 1'b0;
      @(negedge clk);
      check_val("drop_en", lcd_en, 0);
      check_val("drop_on", lcd_on_pin, 0);
      check_val("drop_rdy", cmd_rdy, 0);
      check_val("drop_done", init_done, 0);
      check_val("drop_data", lcd_data, 0);
      repeat (2) @(negedge clk);
      clear_pulses();
      lcd_on = 1'b1;
      wait_init(n);
      check_val("reinit_cycles", n, INIT_CYCLES);
      check_init_pulses("reinit");

      // Asynchronous reset in the middle of a long wait.
      apply_stimulus(1'b0, 8'h01, 1'b0, n);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_on", lcd_on_pin, 0);
      check_val("async_rst_en", lcd_en, 0);
      check_val("async_rst_rdy", cmd_rdy, 0);
      check_val("async_rst_done", init_done, 0);
      check_val("async_rst_data", lcd_data, 0);
      check_val("async_rst_rs", lcd_rs, 0);
      repeat (2) @(negedge clk);
      clear_pulses();
      rst = 1'b0;
      wait_init(n);
      check_val("rst_reinit_cycles", n, INIT_CYCLES);
      check_init_pulses("rstinit");

      base = pq_data.size();
      apply_stimulus(1'b1, 8'h7E, 1'b0, n);
      measure_latency(lat, rise);
      check_val("final_lat", lat, 12);
      check_val("final_pulse_count", pq_data.size(), base + 1);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
